// File: rtl/prf_wbq.sv
// prf_wbq: physical register file fronted by an in-order write-back staging queue.
// Results beyond the array's write ports wait in the queue; reads bypass incoming writes, then the queue, then the array.
`ifndef N
`define N 2
`endif

module prf_wbq #(
   parameter int SIZE      = 64,
   parameter int ARCH_SZ   = 32,
   parameter int DATA_W    = 32,
   parameter int NUM_READ  = 2*`N,
   parameter int NUM_WRITE = `N,
   parameter int NUM_WPORT = 1,
   parameter int NUM_INVAL = `N,
   parameter int QDEPTH    = 8,
   localparam int PRN_W    = $clog2(SIZE),
   localparam int CNT_W    = $clog2(QDEPTH+1)
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [NUM_READ-1:0][PRN_W-1:0]   read_prn,
   output logic [NUM_READ-1:0][DATA_W-1:0]  read_value,
   output logic [NUM_READ-1:0]              read_valid,
   input  logic [NUM_WRITE-1:0]             wr_valid,
   input  logic [NUM_WRITE-1:0][PRN_W-1:0]  wr_prn,
   input  logic [NUM_WRITE-1:0][DATA_W-1:0] wr_data,
   input  logic [NUM_INVAL-1:0][PRN_W-1:0]  inval_prn,
   output logic                             wr_stall,
   output logic [CNT_W-1:0]                 q_count,
   output logic [PRN_W-1:0]                 valid_count,
   output logic                             overflow
);
   localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int LIST_SZ = QDEPTH + NUM_WRITE;
   localparam int LIST_W  = $clog2(LIST_SZ);

   logic [SIZE-1:0]   arr_valid;
   logic [DATA_W-1:0] arr_value [SIZE];
   logic [PRN_W-1:0]  q_prn  [QDEPTH];
   logic [DATA_W-1:0] q_data [QDEPTH];
   logic [PTR_W-1:0]  q_head;

   logic [PRN_W-1:0]  lst_prn  [LIST_SZ];
   logic [DATA_W-1:0] lst_data [LIST_SZ];
   int                n_total;
   int                n_drain;
   int                n_keep;
   logic              drop;
   logic [NUM_WPORT-1:0] aw_en;
   logic [PRN_W-1:0]  aw_prn  [NUM_WPORT];
   logic [DATA_W-1:0] aw_data [NUM_WPORT];
   logic [PRN_W-1:0]  nq_prn  [QDEPTH];
   logic [DATA_W-1:0] nq_data [QDEPTH];
   logic [PTR_W-1:0]  nq_head;
   logic [SIZE-1:0]   nvalid;
   logic [PRN_W-1:0]  nvalid_count;

   function automatic logic is_killed(input logic [PRN_W-1:0] prn,
                                      input logic [NUM_INVAL-1:0][PRN_W-1:0] inv);
      logic k;
      k = 1'b0;
      for (int v = 0; v < NUM_INVAL; v++)
         if (inv[v] != '0 && inv[v] == prn) k = 1'b1;
      return k;
   endfunction

   // Age-ordered candidate list: surviving queue entries oldest-first, then live incoming writes in port order.
   // Incoming writes hitting a same-cycle invalidate are stale and never enter the list, so they cannot resurrect the PRN.
   always_comb begin
      int n;
      int slot;
      n = 0;
      slot = 0;
      for (int k = 0; k < LIST_SZ; k++) begin
         lst_prn[k]  = '0;
         lst_data[k] = '0;
      end
      for (int i = 0; i < QDEPTH; i++) begin
         slot = (int'(q_head) + i) % QDEPTH;
         if (i < int'(q_count) && !is_killed(q_prn[PTR_W'(slot)], inval_prn)) begin
            lst_prn[LIST_W'(n)]  = q_prn[PTR_W'(slot)];
            lst_data[LIST_W'(n)] = q_data[PTR_W'(slot)];
            n = n + 1;
         end
      end
      for (int w = 0; w < NUM_WRITE; w++) begin
         if (wr_valid[w] && wr_prn[w] != '0 && !is_killed(wr_prn[w], inval_prn)) begin
            lst_prn[LIST_W'(n)]  = wr_prn[w];
            lst_data[LIST_W'(n)] = wr_data[w];
            n = n + 1;
         end
      end
      n_total = n;
   end

   // The head of the list drains into the array; the rest is re-laid out compactly behind the advanced head.
   always_comb begin
      int dst;
      dst     = 0;
      n_drain = (n_total < NUM_WPORT) ? n_total : NUM_WPORT;
      n_keep  = ((n_total - n_drain) < QDEPTH) ? (n_total - n_drain) : QDEPTH;
      drop    = (n_total - n_drain) > QDEPTH;
      for (int p = 0; p < NUM_WPORT; p++) begin
         aw_en[p]   = (p < n_drain);
         aw_prn[p]  = lst_prn[LIST_W'(p)];
         aw_data[p] = lst_data[LIST_W'(p)];
      end
      nq_head = PTR_W'((int'(q_head) + n_drain) % QDEPTH);
      for (int j = 0; j < QDEPTH; j++) begin
         nq_prn[j]  = q_prn[j];
         nq_data[j] = q_data[j];
      end
      for (int j = 0; j < QDEPTH; j++) begin
         if (j < n_keep) begin
            dst = (int'(nq_head) + j) % QDEPTH;
            nq_prn[PTR_W'(dst)]  = lst_prn[LIST_W'(n_drain + j)];
            nq_data[PTR_W'(dst)] = lst_data[LIST_W'(n_drain + j)];
         end
      end
      nvalid = arr_valid;
      for (int p = 0; p < NUM_WPORT; p++)
         if (aw_en[p]) nvalid[aw_prn[p]] = 1'b1;
      for (int v = 0; v < NUM_INVAL; v++)
         if (inval_prn[v] != '0) nvalid[inval_prn[v]] = 1'b0;
      nvalid_count = '0;
      for (int i = 1; i < SIZE; i++)
         nvalid_count = nvalid_count + PRN_W'(nvalid[i]);
   end

   // Three-level bypass: highest incoming port, then youngest queued entry, then the array.
   always_comb begin
      int   slot;
      logic hit;
      slot = 0;
      hit  = 1'b0;
      for (int r = 0; r < NUM_READ; r++) begin
         read_value[r] = '0;
         read_valid[r] = 1'b0;
         hit = 1'b0;
         if (read_prn[r] == '0) begin
            read_valid[r] = 1'b1;
         end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (wr_valid[w] && wr_prn[w] == read_prn[r]) begin
                  read_value[r] = wr_data[w];
                  hit = 1'b1;
               end
            end
            if (!hit) begin
               for (int i = 0; i < QDEPTH; i++) begin
                  slot = (int'(q_head) + i) % QDEPTH;
                  if (i < int'(q_count) && q_prn[PTR_W'(slot)] == read_prn[r]) begin
                     read_value[r] = q_data[PTR_W'(slot)];
                     hit = 1'b1;
                  end
               end
            end
            if (hit) begin
               read_valid[r] = 1'b1;
            end else begin
               read_value[r] = arr_value[read_prn[r]];
               read_valid[r] = arr_valid[read_prn[r]];
            end
         end
      end
   end

   // Later array write ports carry younger results, so they overwrite earlier ones for the same PRN.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SIZE; i++) begin
            arr_valid[i] <= (i < ARCH_SZ);
            arr_value[i] <= '0;
         end
         for (int j = 0; j < QDEPTH; j++) begin
            q_prn[j]  <= '0;
            q_data[j] <= '0;
         end
         q_head      <= '0;
         q_count     <= '0;
         wr_stall    <= 1'b0;
         overflow    <= 1'b0;
         valid_count <= PRN_W'(ARCH_SZ - 1);
      end else begin
         arr_valid <= nvalid;
         for (int p = 0; p < NUM_WPORT; p++)
            if (aw_en[p]) arr_value[aw_prn[p]] <= aw_data[p];
         for (int j = 0; j < QDEPTH; j++) begin
            q_prn[j]  <= nq_prn[j];
            q_data[j] <= nq_data[j];
         end
         q_head      <= nq_head;
         q_count     <= CNT_W'(n_keep);
         wr_stall    <= (QDEPTH - n_keep) < NUM_WRITE;
         overflow    <= overflow | drop;
         valid_count <= nvalid_count;
      end
   end

endmodule

// File: tb/tb_prf_wbq.sv
// tb_prf_wbq: scoreboard-driven bench for prf_wbq with two write ports, one array port and a 4-deep queue.
module tb_prf_wbq;
   localparam int SIZE = 64, ARCH_SZ = 32, DW = 32, NR = 4, NW = 2, NP = 1, NI = 2, QD = 4;
   localparam int PW = 6, CW = 3;

   typedef struct packed {
      logic [DW-1:0] value;
      logic          valid;
   } rd_exp_t;

   logic                    clock = 1'b0;
   logic                    reset_n = 1'b0;
   logic [NR-1:0][PW-1:0]   read_prn;
   logic [NR-1:0][DW-1:0]   read_value;
   logic [NR-1:0]           read_valid;
   logic [NW-1:0]           wr_valid;
   logic [NW-1:0][PW-1:0]   wr_prn;
   logic [NW-1:0][DW-1:0]   wr_data;
   logic [NI-1:0][PW-1:0]   inval_prn;
   logic                    wr_stall;
   logic [CW-1:0]           q_count;
   logic [PW-1:0]           valid_count;
   logic                    overflow;

   rd_exp_t sb[$];
   rd_exp_t e;
   int      checks = 0;
   int      passes = 0;

   prf_wbq #(
      .SIZE(SIZE), .ARCH_SZ(ARCH_SZ), .DATA_W(DW), .NUM_READ(NR), .NUM_WRITE(NW),
      .NUM_WPORT(NP), .NUM_INVAL(NI), .QDEPTH(QD)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .read_prn(read_prn), .read_value(read_value), .read_valid(read_valid),
      .wr_valid(wr_valid), .wr_prn(wr_prn), .wr_data(wr_data),
      .inval_prn(inval_prn), .wr_stall(wr_stall), .q_count(q_count),
      .valid_count(valid_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic rd_exp_t mk(input logic [DW-1:0] v, input logic ok);
      rd_exp_t t;
      t.value = v;
      t.valid = ok;
      return t;
   endfunction

   task automatic idle();
      wr_valid  = '0;
      wr_prn    = '0;
      wr_data   = '0;
      inval_prn = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      idle();
      read_prn = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      read_prn[0] = 6'd5;
      read_prn[1] = 6'd40;
      sb.push_back(mk(32'h0, 1'b1));
      sb.push_back(mk(32'h0, 1'b0));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL rst_prn5: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      e = sb.pop_front(); checks++;
      if (read_valid[1] !== e.valid)
         $display("[TB] FAIL rst_prn40: got valid=%b, expected valid=%b", read_valid[1], e.valid);
      else passes++;
      checks++;
      if (valid_count !== 6'd31) $display("[TB] FAIL rst_valid_count: got %0d, expected 31", valid_count);
      else passes++;
      checks++;
      if (q_count !== 3'd0) $display("[TB] FAIL rst_q_count: got %0d, expected 0", q_count);
      else passes++;
      checks++;
      if (wr_stall !== 1'b0 || overflow !== 1'b0)
         $display("[TB] FAIL rst_flags: got stall=%b overflow=%b, expected 0 0", wr_stall, overflow);
      else passes++;
   endtask

   task automatic test_bypass();
      wr_valid = 2'b11;
      wr_prn[0] = 6'd40; wr_data[0] = 32'hAAAA;
      wr_prn[1] = 6'd41; wr_data[1] = 32'hBBBB;
      read_prn[0] = 6'd40;
      read_prn[1] = 6'd41;
      sb.push_back(mk(32'hAAAA, 1'b1));
      sb.push_back(mk(32'hBBBB, 1'b1));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL byp_same_rd40: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL byp_same_rd41: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
      step();
      idle();
      sb.push_back(mk(32'hAAAA, 1'b1));
      sb.push_back(mk(32'hBBBB, 1'b1));
      #1;
      checks++;
      if (q_count !== 3'd1) $display("[TB] FAIL byp_q_count1: got %0d, expected 1", q_count);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL byp_arr_rd40: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL byp_queue_rd41: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
      sb.push_back(mk(32'hBBBB, 1'b1));
      step();
      checks++;
      if (q_count !== 3'd0) $display("[TB] FAIL byp_q_count0: got %0d, expected 0", q_count);
      else passes++;
      checks++;
      if (valid_count !== 6'd33) $display("[TB] FAIL byp_valid_count: got %0d, expected 33", valid_count);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL byp_drained_rd41: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
   endtask

   task automatic test_inval_kill();
      logic [PW-1:0] prns [6] = '{6'd42, 6'd43, 6'd44, 6'd57, 6'd58, 6'd50};
      read_prn[0] = 6'd50;
      read_prn[1] = 6'd58;
      for (int c = 0; c < 3; c++) begin
         wr_valid = 2'b11;
         wr_prn[0] = prns[2*c];   wr_data[0] = 32'hC000 + 32'(prns[2*c]);
         wr_prn[1] = prns[2*c+1]; wr_data[1] = (prns[2*c+1] == 6'd50) ? 32'h1234 : 32'hC000 + 32'(prns[2*c+1]);
         step();
      end
      idle();
      sb.push_back(mk(32'h1234, 1'b1));
      #1;
      checks++;
      if (q_count !== 3'd3 || wr_stall !== 1'b1)
         $display("[TB] FAIL kill_pre_q: got q_count=%0d stall=%b, expected 3 1", q_count, wr_stall);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL kill_queued_rd50: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      inval_prn[0] = 6'd50;
      step();
      idle();
      checks++;
      if (q_count !== 3'd1) $display("[TB] FAIL kill_q_count: got %0d, expected 1", q_count);
      else passes++;
      for (int i = 0; i < 10 && q_count != 3'd0; i++) step();
      checks++;
      if (q_count !== 3'd0) $display("[TB] FAIL kill_drain_timeout: got q_count=%0d, expected 0", q_count);
      else passes++;
      sb.push_back(mk(32'h0, 1'b0));
      sb.push_back(mk(32'hC000 + 32'd58, 1'b1));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL kill_final_rd50: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL kill_final_rd58: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
      checks++;
      if (valid_count !== 6'd38) $display("[TB] FAIL kill_valid_count: got %0d, expected 38", valid_count);
      else passes++;
   endtask

   task automatic test_collision();
      wr_valid = 2'b01;
      wr_prn[0] = 6'd45; wr_data[0] = 32'h4545;
      inval_prn[0] = 6'd45;
      read_prn[0] = 6'd45;
      sb.push_back(mk(32'h4545, 1'b1));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL coll_same_rd45: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      step();
      idle();
      sb.push_back(mk(32'h0, 1'b0));
      #1;
      e = sb.pop_front(); checks++;
      if (read_valid[0] !== e.valid)
         $display("[TB] FAIL coll_after_rd45: got valid=%b, expected valid=%b", read_valid[0], e.valid);
      else passes++;
      checks++;
      if (valid_count !== 6'd38 || q_count !== 3'd0)
         $display("[TB] FAIL coll_counts: got valid_count=%0d q_count=%0d, expected 38 0", valid_count, q_count);
      else passes++;
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] prns [10] = '{6'd46, 6'd47, 6'd48, 6'd49, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55, 6'd56};
      logic [CW-1:0] exp_q  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      logic          exp_st [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic          exp_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 5; c++) begin
         wr_valid = 2'b11;
         wr_prn[0] = prns[2*c];   wr_data[0] = 32'hB000 + 32'(prns[2*c]);
         wr_prn[1] = prns[2*c+1]; wr_data[1] = 32'hB000 + 32'(prns[2*c+1]);
         step();
         idle();
         checks++;
         if (q_count !== exp_q[c] || wr_stall !== exp_st[c] || overflow !== exp_ov[c])
            $display("[TB] FAIL bp_cycle%0d: got q_count=%0d stall=%b overflow=%b, expected %0d %b %b",
                     c, q_count, wr_stall, overflow, exp_q[c], exp_st[c], exp_ov[c]);
         else passes++;
      end
      read_prn[0] = 6'd56;
      read_prn[1] = 6'd55;
      sb.push_back(mk(32'h0, 1'b0));
      sb.push_back(mk(32'hB000 + 32'd55, 1'b1));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
         $display("[TB] FAIL bp_dropped_rd56: got valid=%b value=%h, expected valid=%b value=%h", read_valid[0], read_value[0], e.valid, e.value);
      else passes++;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL bp_queued_rd55: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
      // Reset while 55 is still queued: it must never land in the array.
      reset_n = 1'b0;
      #1;
      checks++;
      if (q_count !== 3'd0 || overflow !== 1'b0 || wr_stall !== 1'b0 || valid_count !== 6'd31)
         $display("[TB] FAIL bp_midreset: got q_count=%0d overflow=%b stall=%b valid_count=%0d, expected 0 0 0 31",
                  q_count, overflow, wr_stall, valid_count);
      else passes++;
      #3 reset_n = 1'b1;
      sb.push_back(mk(32'h0, 1'b0));
      #1;
      e = sb.pop_front(); checks++;
      if ({read_valid[1], read_value[1]} !== {e.valid, e.value})
         $display("[TB] FAIL bp_discarded_rd55: got valid=%b value=%h, expected valid=%b value=%h", read_valid[1], read_value[1], e.valid, e.value);
      else passes++;
   endtask

   task automatic test_wrap();
      logic [DW-1:0] model_val [SIZE];
      logic          written   [SIZE];
      logic [PW-1:0] p;
      for (int i = 0; i < SIZE; i++) begin
         model_val[i] = '0;
         written[i]   = 1'b0;
      end
      step();
      for (int c = 0; c < 20; c++) begin
         idle();
         if (wr_stall == 1'b0) begin
            for (int w = 0; w < NW; w++) begin
               wr_valid[w] = 1'($urandom_range(0, 1));
               p = PW'($urandom_range(33, 63));
               wr_prn[w]  = p;
               wr_data[w] = $urandom;
               if (wr_valid[w]) begin
                  model_val[p] = wr_data[w];
                  written[p]   = 1'b1;
               end
            end
         end
         step();
         checks++;
         if (q_count > CW'(QD)) $display("[TB] FAIL wrap_q_bound: got q_count=%0d, expected <= %0d", q_count, QD);
         else passes++;
      end
      idle();
      for (int i = 0; i < 12 && q_count != 3'd0; i++) step();
      checks++;
      if (q_count !== 3'd0 || overflow !== 1'b0)
         $display("[TB] FAIL wrap_drain: got q_count=%0d overflow=%b, expected 0 0", q_count, overflow);
      else passes++;
      for (int i = 33; i < SIZE; i++) begin
         if (written[i]) begin
            read_prn[0] = PW'(i);
            sb.push_back(mk(model_val[i], 1'b1));
            #1;
            e = sb.pop_front(); checks++;
            if ({read_valid[0], read_value[0]} !== {e.valid, e.value})
               $display("[TB] FAIL wrap_rd%0d: got valid=%b value=%h, expected valid=%b value=%h", i, read_valid[0], read_value[0], e.valid, e.value);
            else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_inval_kill();
      test_collision();
      test_backpressure();
      test_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/prf_wbq.md
# prf_wbq

Parametrised physical register file with a write-back staging queue. It lets the execute stage complete more results per cycle (NUM_WRITE) than the array has write ports (NUM_WPORT). Excess results are held in an in-order queue and drained into the array on later cycles. Every read port sees the freshest value through a three-level bypass: incoming write, then queued write, then array. It replaces the fixed-N register file between issue/execute and commit.

## Interface
- SIZE, 64: physical registers; PRN width = $clog2(SIZE).
- ARCH_SZ, 32: entries valid after reset (PRN 0..ARCH_SZ-1).
- DATA_W, 32: register data width.
- NUM_READ, 2*`N: read ports.
- NUM_WRITE, `N: write requests accepted per cycle.
- NUM_WPORT, 1: array write ports per cycle; must satisfy 1 <= NUM_WPORT <= NUM_WRITE.
- NUM_INVAL, `N: invalidate ports.
- QDEPTH, 8: staging queue depth; must be >= NUM_WRITE.
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_prn  in  NUM_READ x PRN  read addresses.
- read_value  out  NUM_READ x DATA_W  bypassed data.
- read_valid  out  NUM_READ  data-ready bit.
- wr_valid  in  NUM_WRITE  write request; ignored when the matching wr_prn is 0.
- wr_prn  in  NUM_WRITE x PRN  destination.
- wr_data  in  NUM_WRITE x DATA_W  result.
- inval_prn  in  NUM_INVAL x PRN  clear valid bit; 0 = no-op.
- wr_stall  out  1  registered; upstream must not assert wr_valid while high.
- q_count  out  $clog2(QDEPTH+1)  queued entries.
- valid_count  out  PRN  valid array entries, excluding PRN 0.
- overflow  out  1  sticky; set when a write is dropped for lack of space.

## Operation
- Write selection each cycle: form an ordered list of queue entries oldest-first, followed by valid incoming writes in port order.
  - The first NUM_WPORT elements of the list write the array: valid=1, value=data.
  - The remaining incoming writes are appended to the queue tail in port order.
  - Incoming writes beyond the free space are dropped and set overflow.
- Queue is a circular buffer with head/tail pointers that wrap modulo QDEPTH. q_count = occupancy after each edge.
- wr_stall is registered: next wr_stall = (QDEPTH - next q_count) < NUM_WRITE.
- Invalidate:
  - Clears the array valid bit for that PRN.
  - Kills any queued entry with the same PRN, which is removed without writing. Queue compaction preserves the age order of the remaining entries.
  - Overrides an array write to the same PRN in the same cycle, so the PRN ends invalid.
  - A reallocated PRN cannot be resurrected by a stale queued write.
- Read, in priority order:
  - PRN 0: value 0, valid 1.
  - Otherwise, the highest-numbered incoming write port matching the PRN.
  - Otherwise, the youngest matching queue entry.
  - Otherwise, the array entry.
  - A match at either bypass level forces valid=1.
- Two writes to one PRN in a cycle: the higher port index wins for the array. Both are queued if unwritten; the younger one is drained last.
- valid_count: +1 for each array entry going invalid→valid, −1 for each going valid→invalid. Updates are per edge and exclude PRN 0.

## Timing
- Reset (reset_n low, async):
  - Entries 0..ARCH_SZ-1 = {valid 1, value 0}; the rest = {valid 0, value 0}.
  - Queue empty, q_count 0, wr_stall 0, overflow 0, valid_count ARCH_SZ-1.
  - Asserting reset mid-drain discards queued writes.
- Reads are combinational; an incoming write is visible on read ports in the same cycle.
- Array and queue updates take effect at the next rising edge.
- Drain latency: a write queued at position k (0 = head) reaches the array floor(k/NUM_WPORT)+1 edges after enqueue, absent kills. It remains readable through the queue bypass throughout.
- Queue full: new writes are accepted only up to the slots freed by same-cycle drains.
- Queue empty: incoming writes go straight to the array up to NUM_WPORT.

## Test plan
- Reset: after reset_n release, read PRN 5 -> value 0, valid 1; read PRN 40 -> valid 0; valid_count 31, q_count 0, wr_stall 0.
- Same-cycle bypass (N=2, NUM_WPORT=1): write {PRN 40 = 0xAAAA, PRN 41 = 0xBBBB} while reading 40/41.
  - Same cycle: both reads valid with those values.
  - Next cycle: q_count 1.
  - Following cycle: q_count 0 and array holds 0xBBBB; valid_count 33.
- Backpressure (QDEPTH=4, NUM_WRITE=2, NUM_WPORT=1): two writes per cycle for 3 cycles -> wr_stall rises once q_count >= 3. Forcing a further write pair -> overflow=1 and the dropped PRN reads valid 0.
- Invalidate kills queued write: queue PRN 50 = 0x1234 behind two entries, then inval_prn = 50 -> q_count drops by 1. After full drain, PRN 50 reads valid 0.
- Write/invalidate collision in the same cycle on PRN 45 -> PRN 45 valid 0 after the edge; valid_count unchanged.
- Wrap-around: 20 cycles of random writes with stall honoured -> every PRN reads its last-written value; q_count never exceeds QDEPTH; overflow stays 0.
